// File: rtl/prio_enc_lf_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : prio_enc_lf_pipe
//  Purpose  : Pipelined priority encoder. Each accepted word is reduced with a
//             Ladner-Fischer (minimum-depth) parallel-prefix OR network. The
//             network always gives the MSB priority; words flagged
//             LSB-first are bit-reversed on entry and their one-hot result is
//             reversed back on exit. A register stage follows every two prefix
//             levels and the final stage holds the outputs, giving
//             LAT = ceil(log2(WIDTH)/2) + 1 register stages (4 for WIDTH=32).
//  Macro    : PRIO_ENC_IDX_EN - when defined, adds the out_idx port with a
//             binary encoder registered alongside out_onehot.
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             in_valid/in_ready - upstream handshake
//             in_data           - request vector (WIDTH bits)
//             in_lsb_first      - per-word priority mode (1 = LSB wins)
//             out_valid/out_ready - downstream handshake
//             out_onehot        - one-hot winner, zero for a zero word
//             out_any           - OR of the accepted word
//             out_idx           - binary winner index (PRIO_ENC_IDX_EN only)
//  Revision : 1.0 - initial release
// ============================================================================
module prio_enc_lf_pipe #(
    parameter int WIDTH = 32,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_lsb_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_onehot,
    output logic             out_any
`ifdef PRIO_ENC_IDX_EN
    ,
    output logic [IDXW-1:0]  out_idx
`endif
);

    localparam int C_NLVL = IDXW;
    localparam int C_NSTG = (C_NLVL + 1) / 2;

    // Merge source for bit i at prefix level lvl, or -1 for a pass-through.
    // The prefix runs from the MSB downward: position k = WIDTH-1-i, and in
    // each block of 2^lvl positions the upper half ORs in the last element of
    // the lower half (Sklansky / minimum-depth Ladner-Fischer).
    function automatic int f_src(input int i, input int lvl);
        int k;
        int blk;
        k   = WIDTH - 1 - i;
        blk = k >> (lvl - 1);
        if (lvl > C_NLVL || (blk % 2) == 0) begin
            return -1;
        end
        return WIDTH - (blk << (lvl - 1));
    endfunction

    logic             w_advance;
    logic [WIDTH-1:0] w_in_rev;
    logic [WIDTH-1:0] w_in_net;
    logic [WIDTH-1:0] w_sout  [C_NSTG];
    logic [C_NSTG-1:0] w_stg_v;
    logic [C_NSTG-1:0] w_stg_m;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_oh_net;
    logic [WIDTH-1:0] w_oh_rev;
    logic [WIDTH-1:0] w_oh;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_onehot;
    logic             r_any;

    // The whole pipeline moves as one; it freezes only when the output
    // register holds a result the consumer has not taken.
    assign w_advance = !(r_out_valid && !out_ready);
    assign in_ready  = w_advance;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_rev
            assign w_in_rev[i] = in_data[WIDTH-1-i];
            assign w_oh_rev[i] = w_oh_net[WIDTH-1-i];
        end
    endgenerate

    assign w_in_net = in_lsb_first ? w_in_rev : in_data;

    // ------------------------------------------------------------------------
    // Stage s register holds the prefix vector after 2*s levels; its two
    // following levels feed the next stage (or the output register).
    // ------------------------------------------------------------------------
    generate
        for (genvar s = 0; s < C_NSTG; s++) begin : g_stage
            logic [WIDTH-1:0] r_x;
            logic             r_v;
            logic             r_m;
            logic [WIDTH-1:0] w_a;
            logic [WIDTH-1:0] w_b;

            if (s == 0) begin : g_head
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_x <= '0;
                        r_v <= 1'b0;
                        r_m <= 1'b0;
                    end else if (w_advance) begin
                        r_x <= w_in_net;
                        r_v <= in_valid;
                        r_m <= in_lsb_first;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_x <= '0;
                        r_v <= 1'b0;
                        r_m <= 1'b0;
                    end else if (w_advance) begin
                        r_x <= w_sout[s-1];
                        r_v <= w_stg_v[s-1];
                        r_m <= w_stg_m[s-1];
                    end
                end
            end

            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                localparam int SA = f_src(i, 2*s + 1);
                localparam int SB = f_src(i, 2*s + 2);
                if (SA < 0) begin : g_pass_a
                    assign w_a[i] = r_x[i];
                end else begin : g_or_a
                    assign w_a[i] = r_x[i] | r_x[SA];
                end
                if (SB < 0) begin : g_pass_b
                    assign w_b[i] = w_a[i];
                end else begin : g_or_b
                    assign w_b[i] = w_a[i] | w_a[SB];
                end
            end

            assign w_sout[s]  = w_b;
            assign w_stg_v[s] = r_v;
            assign w_stg_m[s] = r_m;
        end
    endgenerate

    // w_p[i] = OR of network bits [WIDTH-1:i]; bit i wins when it is the
    // first set bit from the top, i.e. w_p[i] rises and w_p[i+1] is clear.
    assign w_p      = w_sout[C_NSTG-1];
    assign w_oh_net = w_p & ~{1'b0, w_p[WIDTH-1:1]};
    assign w_oh     = w_stg_m[C_NSTG-1] ? w_oh_rev : w_oh_net;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_onehot    <= '0;
            r_any       <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= w_stg_v[C_NSTG-1];
            r_onehot    <= w_oh;
            r_any       <= w_p[0];
        end
    end

    assign out_valid  = r_out_valid;
    assign out_onehot = r_onehot;
    assign out_any    = r_any;

`ifdef PRIO_ENC_IDX_EN
    // Index bit b is the OR of every one-hot position whose index has bit b set.
    logic [WIDTH-1:0] w_sel [IDXW];
    logic [IDXW-1:0]  w_idx;
    logic [IDXW-1:0]  r_idx;

    generate
        for (genvar b = 0; b < IDXW; b++) begin : g_idx
            for (genvar i = 0; i < WIDTH; i++) begin : g_sel
                if (((i >> b) % 2) == 1) begin : g_on
                    assign w_sel[b][i] = w_oh[i];
                end else begin : g_off
                    assign w_sel[b][i] = 1'b0;
                end
            end
            assign w_idx[b] = |w_sel[b];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_advance) begin
            r_idx <= w_idx;
        end
    end

    assign out_idx = r_idx;
`endif

endmodule
`default_nettype wire
